// File: rtl/aes_pkg.sv
// Shared AES definitions: key/word widths, round count, GF(2^8) doubling
// and the key-schedule state encoding.
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_NR     = 10;

  typedef enum logic {
    IDLE,
    EMIT
  } ke_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational 256-entry lookup.
// Shared by the key schedule and the byte_sub datapath.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Entry 0 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base = 11'd2047 - {x, 3'b000};
  assign y    = SBOX[base -: 8];

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: streams round keys 0..10 one per handshake,
// computing each next key from the current one in a single cycle.
//
// state | meaning
// IDLE  | key_ready=1, waiting for key_load
// EMIT  | rk_valid=1, presenting round key rk_idx until rk_ready
module key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 key_load,
  output logic                 key_ready,
  output logic [AES_KEY_W-1:0] rk_out,
  output logic [3:0]           rk_idx,
  output logic                 rk_last,
  output logic                 rk_valid,
  input  logic                 rk_ready
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ke_state_t state_q, state_d;

  logic [AES_KEY_W-1:0]  key_q, key_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            rcon_q, rcon_d;

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;
  logic [AES_WORD_W-1:0] rot_w3, sub_w3, t;
  logic [AES_WORD_W-1:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .x (rot_w3[8*g +: 8]),
        .y (sub_w3[8*g +: 8])
      );
    end
  endgenerate

  assign t  = sub_w3 ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign rk_out    = key_q;
  assign rk_idx    = idx_q;
  assign rk_last   = rk_valid && (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (key_load) begin
          key_d   = key_in;
          idx_d   = '0;
          rcon_d  = 8'h01;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            key_d  = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_expand.sv
// Directed bench for key_expand using FIPS-197 A.1 and all-zero key schedules.
module tb_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cyc_load = 0;
  int cyc_last = 0;

  logic [127:0] exp_tbl [2][11];

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  key_expand #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    @(negedge clk);
    chk("load_ready", 128'(key_ready), 128'(1));
    key_in   = k;
    key_load = 1'b1;
    cyc_load = cyc;
    @(posedge clk);
    #1 key_load = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready with 5-cycle stall at idx 3,
  // 2: always ready with a stray key_load at idx 4
  task automatic drain(input int which, input int mode);
    int n;
    int guard;
    int stall_left;
    bit stall_done;
    bit was_stalled;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    n = 0; guard = 0; stall_left = 0; stall_done = 0; was_stalled = 0;
    prev_out = '0; prev_idx = '0;
    while (n < 11 && guard < 300) begin
      @(negedge clk);
      guard++;
      key_load = 1'b0;
      if (was_stalled) begin
        chk("stall_out", rk_out, prev_out);
        chk("stall_idx", 128'(rk_idx), 128'(prev_idx));
      end
      case (mode)
        1: begin
          if (!stall_done && rk_valid && rk_idx == 4'd3) begin
            stall_left = 5;
            stall_done = 1'b1;
          end
          if (stall_left > 0) begin
            rk_ready = 1'b0;
            stall_left--;
          end else begin
            rk_ready = 1'($urandom_range(0, 1));
          end
        end
        2: begin
          rk_ready = 1'b1;
          if (rk_valid && rk_idx == 4'd4) begin
            key_load = 1'b1;
            key_in   = '1;
          end
          chk("busy_ready", 128'(key_ready), 128'(0));
        end
        default: rk_ready = 1'b1;
      endcase
      was_stalled = rk_valid && !rk_ready;
      prev_out = rk_out;
      prev_idx = rk_idx;
      if (rk_valid && rk_ready) begin
        chk("rk_idx", 128'(rk_idx), 128'(n));
        chk("rk_out", rk_out, exp_tbl[which][n]);
        chk("rk_last", 128'(rk_last), 128'(n == 10));
        if (n == 10) cyc_last = cyc;
        n++;
      end
    end
    if (n != 11) chk("drain_timeout", 128'(n), 128'(11));
    key_load = 1'b0;
  endtask

  initial begin
    int g;
    int first_load;

    exp_tbl[0][0]  = KEY_A1;
    exp_tbl[0][1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_tbl[0][2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_tbl[0][3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_tbl[0][4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_tbl[0][5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_tbl[0][6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_tbl[0][7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_tbl[0][8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_tbl[0][9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_tbl[0][10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_tbl[1][0]  = KEY_ZERO;
    exp_tbl[1][1]  = 128'h62636363626363636263636362636363;
    exp_tbl[1][2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    exp_tbl[1][3]  = 128'h90973450696ccffaf2f457330b0fac99;
    exp_tbl[1][4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    exp_tbl[1][5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    exp_tbl[1][6]  = 128'hec614b851425758c99ff09376ab49ba7;
    exp_tbl[1][7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    exp_tbl[1][8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    exp_tbl[1][9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    exp_tbl[1][10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst = 1'b1; key_in = '0; key_load = 1'b0; rk_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_rk_last", 128'(rk_last), 128'(0));
    chk("rst_rk_out", rk_out, 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    rst = 1'b0;

    // A.1 key, full throughput
    load(KEY_A1);
    drain(0, 0);
    @(negedge clk);
    chk("a1_done_ready", 128'(key_ready), 128'(1));
    chk("a1_done_valid", 128'(rk_valid), 128'(0));

    // zero key
    load(KEY_ZERO);
    drain(1, 0);

    // backpressure
    load(KEY_A1);
    drain(0, 1);

    // busy lockout
    load(KEY_A1);
    drain(0, 2);

    // reset in the middle of a sequence
    load(KEY_A1);
    rk_ready = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(rk_valid && rk_idx == 4'd6) && g < 30);
    chk("mid_reach_idx6", 128'(rk_idx), 128'(6));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 128'(rk_valid), 128'(0));
    chk("mid_rst_ready", 128'(key_ready), 128'(1));
    chk("mid_rst_out", rk_out, 128'(0));
    chk("mid_rst_idx", 128'(rk_idx), 128'(0));
    load(KEY_ZERO);
    drain(1, 0);

    // back-to-back keys
    load(KEY_A1);
    first_load = cyc_load;
    drain(0, 0);
    load(KEY_ZERO);
    drain(1, 0);
    chk("b2b_span", 128'(cyc_last - first_load), 128'(23));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_expand.md
# key_expand

AES-128 key-schedule stage that turns a 128-bit cipher key into the 11 round keys (round 0..10), one per handshake. It sits directly upstream of the add-round-key/byte_sub datapath and streams each round key as the round engine consumes it, so no 11×128-bit key store is needed. Round keys are generated on the fly from the previous key, with backpressure from the consumer.

## Interface
- NUM_ROUNDS, 10, number of rounds after round 0; only 10 (AES-128) is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key; FIPS-197 byte order, byte 0 in [127:120].
- key_load  input  1  start request; accepted only when key_ready=1.
- key_ready  output  1  high in IDLE; block can accept a new key.
- rk_out  output  128  current round key; w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
- rk_idx  output  4  round index of rk_out, 0..10.
- rk_last  output  1  high when rk_valid=1 and rk_idx=10.
- rk_valid  output  1  rk_out/rk_idx valid.
- rk_ready  input  1  consumer accepts the current round key.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - key_ready=1, rk_valid=0.
  - When key_load=1: latch key_in into the key register, set rk_idx=0 and rcon=0x01, then go to EMIT.
- EMIT:
  - key_ready=0, rk_valid=1.
  - Transfer occurs when rk_valid & rk_ready.
  - On a transfer with rk_idx<10: replace the key register with the next round key, increment rk_idx, and advance rcon.
  - On a transfer with rk_idx=10: go to IDLE.
- Next round key, all XORs bitwise on 32-bit words:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES S-box to each byte.
  - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
- rcon advance: xtime, i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Sequence: 01,02,04,08,10,20,40,80,1b,36.
- key_load while in EMIT is ignored. key_in is sampled only on the accept cycle.
- Reset values:
  - State IDLE.
  - key_ready=1 from the first cycle after reset.
  - rk_valid=0, rk_last=0.
  - rk_out=0, rk_idx=0, rcon=0x01.
- Reset mid-operation abandons the sequence. Outputs return to the reset values on the next edge, and no further round keys are emitted.

## Timing
- Key accepted at edge N, so rk_valid=1, rk_idx=0 and rk_out=key_in after edge N.
- With rk_ready held high, one round key per cycle with no bubbles. rk_idx 10 is presented at cycle N+10, and key_ready=1 again after edge N+11.
- Back-to-back keys: key_load may be accepted in the first IDLE cycle, giving a minimum 12-cycle period per key.
- Backpressure: while rk_valid=1 and rk_ready=0, rk_out, rk_idx and rk_last stay stable, for any number of cycles.
- Next-key computation is a single combinational cycle: four S-box lookups plus an XOR chain from the key register back to the key register. No output is combinationally driven by rk_ready.
- rk_last is decoded from registered rk_idx and the state.

## Structure
- Shared package aes_pkg holds:
  - AES_KEY_W=128, AES_WORD_W=32, AES_NR=10.
  - Function xtime(byte).
  - The state enum (IDLE, EMIT).
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational 256-entry LUT.
  - key_expand instantiates it four times.
  - The byte-substitution datapath reuses the same module.

## Test plan
- FIPS-197 Appendix A.1 key:
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1.
  - Required: rk_idx 0 equals the key; rk_idx 1 = a0fafe17 88542cb1 23a33939 2a6c7605; rk_idx 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last=1.
  - Required: exactly 11 transfers, then key_ready=1.
- All-zero key:
  - Required: rk_idx 1 = 62636363 62636363 62636363 62636363.
  - Required: rk_idx 2 = 9b9898c9 f9fbfbaa 9b9898c9 f9fbfbaa.
- Backpressure:
  - Stimulus: A.1 key, with rk_ready toggled pseudo-randomly and held low for 5 cycles at rk_idx 3.
  - Required: rk_out/rk_idx are stable while stalled, and the key sequence is identical to the unstalled run.
- Busy lockout:
  - Stimulus: key_load pulsed with key ffff…ff at rk_idx 4 of an A.1 run.
  - Required: the pulse is ignored, the A.1 sequence completes unchanged, and key_ready stays 0 until after rk_idx 10 transfers.
- Mid-operation reset:
  - Stimulus: rst asserted for 1 cycle at rk_idx 6.
  - Required: next cycle shows rk_valid=0, key_ready=1, rk_out=0.
  - Required: a following zero-key load restarts cleanly with rcon=01, giving round 1 = 62636363 62636363 62636363 62636363.
- Back-to-back keys:
  - Stimulus: the A.1 key, then the zero key loaded in the first IDLE cycle.
  - Required: 22 transfers in 24 cycles, and both sequences are correct.
